// File: rtl/mtimer_ctrl_if.sv
// Word-wide MMIO request/acknowledge port of the machine timer controller.
// The requester holds req until ack and drops it in the ack cycle.
interface mtimer_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack,
    input  err
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack,
    output err
  );
endinterface

// File: rtl/mtimer_ctrl.sv
// Machine timer: prescaled 64-bit mtime, staged 64-bit mtimecmp, EN control and a level
// interrupt, all reachable through a one-access-per-two-cycles MMIO req/ack port.
module mtimer_ctrl #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PS_W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  mtimer_ctrl_if.slave bus,
  output logic         irq_mtimecmp
);

  typedef enum logic [0:0] {
    StIdle,
    StAck
  } state_e;

  localparam logic [2:0] AddrMtimeLo = 3'd0;
  localparam logic [2:0] AddrMtimeHi = 3'd1;
  localparam logic [2:0] AddrCmpLo   = 3'd2;
  localparam logic [2:0] AddrCmpHi   = 3'd3;
  localparam logic [2:0] AddrCtrl    = 3'd4;

  localparam logic [PS_W-1:0] PsLast = PS_W'(PRESCALE - 1);

  state_e      state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] stage_q, stage_d;
  logic [31:0] snap_q, snap_d;
  logic        en_q, en_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic        access;

  // Handshake FSM: an access is performed on the edge that leaves StIdle.
  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          access  = 1'b1;
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tick    = en_q && (ps_q == PsLast);
    ps_d    = ps_q;
    mtime_d = mtime_q;
    if (en_q) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
    end
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    cmp_d   = cmp_q;
    stage_d = stage_q;
    snap_d  = snap_q;
    en_d    = en_q;
    rdata_d = '0;
    ack_d   = access;
    err_d   = 1'b0;
    irq_d   = en_q && (mtime_q >= cmp_q);

    if (access && !bus.we) begin
      case (bus.addr)
        AddrMtimeLo: begin
          rdata_d = mtime_q[31:0];
          snap_d  = mtime_q[63:32];
        end
        AddrMtimeHi: rdata_d = snap_q;
        AddrCmpLo:   rdata_d = cmp_q[31:0];
        AddrCmpHi:   rdata_d = cmp_q[63:32];
        AddrCtrl:    rdata_d = {31'd0, en_q};
        default:     err_d   = 1'b1;
      endcase
    end

    // A software write to mtime drops any coincident tick and restarts the prescaler.
    if (access && bus.we) begin
      case (bus.addr)
        AddrMtimeLo: begin
          mtime_d = {mtime_q[63:32], bus.wdata};
          ps_d    = '0;
        end
        AddrMtimeHi: begin
          mtime_d = {bus.wdata, mtime_q[31:0]};
          ps_d    = '0;
        end
        AddrCmpLo:   stage_d = bus.wdata;
        AddrCmpHi:   cmp_d   = {bus.wdata, stage_q};
        AddrCtrl:    en_d    = bus.wdata[0];
        default:     err_d   = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mtime_q <= '0;
      ps_q    <= '0;
      cmp_q   <= '1;
      stage_q <= '1;
      snap_q  <= '0;
      en_q    <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mtime_q <= mtime_d;
      ps_q    <= ps_d;
      cmp_q   <= cmp_d;
      stage_q <= stage_d;
      snap_q  <= snap_d;
      en_q    <= en_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign irq_mtimecmp = irq_q;

endmodule

// File: tb/tb_mtimer_ctrl.sv
// Bench for mtimer_ctrl: two instances (PRESCALE 1 and 4) share one bus stimulus and are
// checked every cycle against a behavioural model, plus a vector table and directed sequences.
module tb_mtimer_ctrl;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        irq1;
  logic        irq4;

  int unsigned n_cmp;
  int unsigned n_bad;

  mtimer_ctrl_if bus1 ();
  mtimer_ctrl_if bus4 ();

  assign bus1.req   = req;
  assign bus1.we    = we;
  assign bus1.addr  = addr;
  assign bus1.wdata = wdata;
  assign bus4.req   = req;
  assign bus4.we    = we;
  assign bus4.addr  = addr;
  assign bus4.wdata = wdata;

  mtimer_ctrl #(.PRESCALE(1), .PS_W(16)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus1),
    .irq_mtimecmp (irq1)
  );

  mtimer_ctrl #(.PRESCALE(4), .PS_W(16)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus4),
    .irq_mtimecmp (irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4.
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2];
  logic [31:0] m_stage [2];
  logic [31:0] m_snap  [2];
  logic [31:0] m_rdata [2];
  int unsigned m_cnt   [2];
  logic        m_en    [2];
  logic        m_ack   [2];
  logic        m_err   [2];
  logic        m_irq   [2];

  function automatic int unsigned pval(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour, using the bus inputs present at the edge.
  task automatic step(input int k);
    logic [63:0] mt;
    int unsigned cn;
    logic        acc;
    logic        irq_n;
    logic [31:0] rd;
    if (reset) begin
      m_mtime[k] = '0;
      m_cmp[k]   = '1;
      m_stage[k] = '1;
      m_snap[k]  = '0;
      m_rdata[k] = '0;
      m_cnt[k]   = 0;
      m_en[k]    = 1'b0;
      m_ack[k]   = 1'b0;
      m_err[k]   = 1'b0;
      m_irq[k]   = 1'b0;
      return;
    end
    acc   = req && !m_ack[k];
    irq_n = m_en[k] && (m_mtime[k] >= m_cmp[k]);
    mt    = m_mtime[k];
    cn    = m_cnt[k];
    rd    = '0;
    if (m_en[k]) begin
      cn = cn + 1;
      if (cn % pval(k) == 0) mt = mt + 64'd1;
    end
    m_err[k] = acc && (addr > 3'd4);
    if (acc && !we) begin
      case (addr)
        3'd0: begin
          rd        = m_mtime[k][31:0];
          m_snap[k] = m_mtime[k][63:32];
        end
        3'd1:    rd = m_snap[k];
        3'd2:    rd = m_cmp[k][31:0];
        3'd3:    rd = m_cmp[k][63:32];
        3'd4:    rd = {31'd0, m_en[k]};
        default: rd = '0;
      endcase
    end
    if (acc && we) begin
      case (addr)
        3'd0: begin
          mt = {m_mtime[k][63:32], wdata};
          cn = 0;
        end
        3'd1: begin
          mt = {wdata, m_mtime[k][31:0]};
          cn = 0;
        end
        3'd2:    m_stage[k] = wdata;
        3'd3:    m_cmp[k]   = {wdata, m_stage[k]};
        3'd4:    m_en[k]    = wdata[0];
        default: ;
      endcase
    end
    m_mtime[k] = mt;
    m_cnt[k]   = cn;
    m_rdata[k] = rd;
    m_ack[k]   = acc;
    m_irq[k]   = irq_n;
  endtask

  task automatic cycle();
    @(posedge clk);
    step(0);
    step(1);
    #1;
    chk("ack[p1]",   {63'd0, bus1.ack}, {63'd0, m_ack[0]});
    chk("err[p1]",   {63'd0, bus1.err}, {63'd0, m_err[0]});
    chk("rdata[p1]", {32'd0, bus1.rdata}, {32'd0, m_rdata[0]});
    chk("irq[p1]",   {63'd0, irq1}, {63'd0, m_irq[0]});
    chk("ack[p4]",   {63'd0, bus4.ack}, {63'd0, m_ack[1]});
    chk("err[p4]",   {63'd0, bus4.err}, {63'd0, m_err[1]});
    chk("rdata[p4]", {32'd0, bus4.rdata}, {32'd0, m_rdata[1]});
    chk("irq[p4]",   {63'd0, irq4}, {63'd0, m_irq[1]});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic access(input logic w, input logic [2:0] a, input logic [31:0] d,
                        output logic [31:0] r1, output logic [31:0] r4, output logic e1);
    req = 1'b1; we = w; addr = a; wdata = d;
    cycle();
    r1 = bus1.rdata;
    r4 = bus4.rdata;
    e1 = bus1.err;
    req = 1'b0; we = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [17];
  logic [31:0] r1, r4;
  logic        e1;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // EN stays 0 throughout the table, so every value is fixed.
    tbl[0]  = '{1'b1, 3'd0, 32'h1234_5678, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 3'd1, 32'hAABB_CCDD, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 3'd1, 32'h0, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 3'd0, 32'h0, 32'h1234_5678, 1'b0};
    tbl[4]  = '{1'b0, 3'd1, 32'h0, 32'hAABB_CCDD, 1'b0};
    tbl[5]  = '{1'b1, 3'd2, 32'h50, 32'h0, 1'b0};
    tbl[6]  = '{1'b0, 3'd2, 32'h0, 32'hFFFF_FFFF, 1'b0};
    tbl[7]  = '{1'b1, 3'd3, 32'h1, 32'h0, 1'b0};
    tbl[8]  = '{1'b0, 3'd2, 32'h0, 32'h50, 1'b0};
    tbl[9]  = '{1'b0, 3'd3, 32'h0, 32'h1, 1'b0};
    tbl[10] = '{1'b0, 3'd4, 32'h0, 32'h0, 1'b0};
    tbl[11] = '{1'b1, 3'd4, 32'hFFFF_FFFE, 32'h0, 1'b0};
    tbl[12] = '{1'b0, 3'd4, 32'h0, 32'h0, 1'b0};
    tbl[13] = '{1'b0, 3'd6, 32'h0, 32'h0, 1'b1};
    tbl[14] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, 1'b1};
    tbl[15] = '{1'b0, 3'd0, 32'h0, 32'h1234_5678, 1'b0};
    tbl[16] = '{1'b0, 3'd5, 32'h0, 32'h0, 1'b1};

    idle(2);
    reset = 1'b0;
    chk("reset irq", {63'd0, irq1}, 64'd0);
    chk("reset ack", {63'd0, bus1.ack}, 64'd0);

    for (int i = 0; i < 17; i++) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, r1, r4, e1);
      chk($sformatf("tbl%0d rdata[p1]", i), {32'd0, r1}, {32'd0, tbl[i].exp_rdata});
      chk($sformatf("tbl%0d rdata[p4]", i), {32'd0, r4}, {32'd0, tbl[i].exp_rdata});
      chk($sformatf("tbl%0d err", i), {63'd0, e1}, {63'd0, tbl[i].exp_err});
    end

    // irq rises one cycle after mtime reaches mtimecmp = 5.
    reset = 1'b1; cycle(); reset = 1'b0;
    access(1'b1, 3'd2, 32'd5, r1, r4, e1);
    access(1'b1, 3'd3, 32'd0, r1, r4, e1);
    access(1'b1, 3'd4, 32'd1, r1, r4, e1);
    idle(4);
    chk("irq before mtime=5 seen", {63'd0, irq1}, 64'd0);
    idle(1);
    chk("irq after mtime=5", {63'd0, irq1}, 64'd1);
    idle(3);
    chk("irq level holds", {63'd0, irq1}, 64'd1);
    chk("irq p4 still low", {63'd0, irq4}, 64'd0);

    // Mid-count mtime write restarts the prescaler.
    access(1'b1, 3'd0, 32'h10, r1, r4, e1);
    idle(2);
    access(1'b0, 3'd0, 32'h0, r1, r4, e1);
    chk("lo after write, p4", {32'd0, r4}, 64'h10);
    chk("lo after write, p1", {32'd0, r1}, 64'h13);
    access(1'b0, 3'd0, 32'h0, r1, r4, e1);
    chk("first tick after write, p4", {32'd0, r4}, 64'h11);
    chk("count after write, p1", {32'd0, r1}, 64'h15);

    // Coherent 64-bit read across a carry.
    access(1'b1, 3'd4, 32'd0, r1, r4, e1);
    access(1'b1, 3'd1, 32'd0, r1, r4, e1);
    access(1'b1, 3'd0, 32'hFFFF_FFFF, r1, r4, e1);
    access(1'b0, 3'd0, 32'h0, r1, r4, e1);
    chk("lo before carry", {32'd0, r4}, 64'hFFFF_FFFF);
    access(1'b1, 3'd4, 32'd1, r1, r4, e1);
    idle(8);
    access(1'b0, 3'd1, 32'h0, r1, r4, e1);
    chk("snapshot hi, p1", {32'd0, r1}, 64'd0);
    chk("snapshot hi, p4", {32'd0, r4}, 64'd0);
    access(1'b0, 3'd0, 32'h0, r1, r4, e1);
    access(1'b0, 3'd1, 32'h0, r1, r4, e1);
    chk("hi after carry, p1", {32'd0, r1}, 64'd1);
    chk("hi after carry, p4", {32'd0, r4}, 64'd1);

    // Staged compare: only the HI write commits.
    access(1'b1, 3'd4, 32'd0, r1, r4, e1);
    access(1'b1, 3'd1, 32'd0, r1, r4, e1);
    access(1'b1, 3'd0, 32'h100, r1, r4, e1);
    access(1'b1, 3'd2, 32'h200, r1, r4, e1);
    access(1'b1, 3'd3, 32'd0, r1, r4, e1);
    access(1'b1, 3'd4, 32'd1, r1, r4, e1);
    idle(2);
    chk("irq below cmp", {63'd0, irq1}, 64'd0);
    access(1'b1, 3'd2, 32'h50, r1, r4, e1);
    chk("irq after stage only", {62'd0, irq1, irq4}, 64'd0);
    req = 1'b1; we = 1'b1; addr = 3'd3; wdata = 32'd0;
    cycle();
    chk("irq lags commit", {62'd0, irq1, irq4}, 64'd0);
    req = 1'b0; we = 1'b0;
    cycle();
    chk("irq after commit", {62'd0, irq1, irq4}, 64'd3);

    // Reset while in the ack cycle with irq high.
    req = 1'b1; we = 1'b0; addr = 3'd0;
    cycle();
    chk("ack before reset", {63'd0, bus1.ack}, 64'd1);
    reset = 1'b1; req = 1'b0;
    cycle();
    reset = 1'b0;
    chk("ack dropped by reset", {63'd0, bus1.ack}, 64'd0);
    chk("irq cleared by reset", {62'd0, irq1, irq4}, 64'd0);
    access(1'b0, 3'd3, 32'h0, r1, r4, e1);
    chk("cmp hi after reset", {32'd0, r1}, 64'hFFFF_FFFF);
    access(1'b0, 3'd2, 32'h0, r1, r4, e1);
    chk("cmp lo after reset", {32'd0, r4}, 64'hFFFF_FFFF);
    access(1'b0, 3'd4, 32'h0, r1, r4, e1);
    chk("en after reset", {32'd0, r1}, 64'd0);

    // Random traffic, including occasional reset mid-transaction.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        req   = 1'b0;
      end else begin
        reset = 1'b0;
        if (req && m_ack[0]) begin
          req = 1'b0;
        end else if (!req && m_ack[0]) begin
          req = 1'b0;
        end else if (!req && $urandom_range(0, 2) != 0) begin
          req  = 1'b1;
          we   = 1'($urandom_range(0, 1));
          addr = 3'($urandom_range(0, 7));
          case ($urandom_range(0, 3))
            0:       wdata = $urandom;
            1:       wdata = 32'($urandom_range(0, 40));
            2:       wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: wdata = 32'd0;
          endcase
          if (addr == 3'd4 && $urandom_range(0, 3) != 0) wdata = 32'd1;
        end
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
